// File: rtl/cycle_sequencer_pkg.sv
// Shared encodings and constants for the mc8051 machine-cycle sequencer.
package cycle_sequencer_pkg;

    localparam int unsigned OPCODE_W = 8;
    localparam int unsigned STAGE_W  = 2;

    localparam logic [STAGE_W-1:0]  CI_STAGE_MAX = 2'b11;
    localparam logic [OPCODE_W-1:0] OPCODE_NOP   = 8'h00;

    typedef enum logic [2:0] {
        SEQ_IDLE = 3'd0,
        SEQ_S1   = 3'd1,
        SEQ_S2   = 3'd2,
        SEQ_S3   = 3'd3,
        SEQ_S4   = 3'd4,
        SEQ_S5   = 3'd5,
        SEQ_S6   = 3'd6
    } seq_state_e;

    // Phases that may stall on a data-memory access.
    function automatic logic is_mem_phase(input seq_state_e s);
        return (s == SEQ_S2) || (s == SEQ_S3) || (s == SEQ_S5);
    endfunction

endpackage

// File: rtl/cycle_sequencer_wait_timer.sv
// seq_wait_timer: counts wait cycles of the current phase and flags expiry
// on the cycle whose edge would make the count reach LIMIT.
module seq_wait_timer #(
    parameter int unsigned LIMIT = 255
) (
    input  logic i_clk,
    input  logic i_rst_n,
    input  logic i_hold,
    input  logic i_wait,
    output logic o_expire_c
);

    localparam int unsigned WAIT_W = 8;

    logic [WAIT_W-1:0] count;

    assign o_expire_c = i_wait && (count == WAIT_W'(LIMIT - 1));

    // Any non-waiting cycle is either a completion or a non-memory state,
    // so clearing on it gives a fresh count on every state entry.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            count <= '0;
        end else if (!i_hold) begin
            if (!i_wait || o_expire_c) begin
                count <= '0;
            end else begin
                count <= count + WAIT_W'(1);
            end
        end
    end

endmodule

// File: rtl/cycle_sequencer.sv
// mc8051 machine-cycle sequencer: walks S1..S6, fetches opcodes, issues phase ticks.
// Optional memory-wait timeout is enabled with `define MC8051_MEM_TIMEOUT_EN.
module cycle_sequencer
    import cycle_sequencer_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = 255
) (
    input  logic                i_clk,
    input  logic                i_rst_n,
    input  logic                i_hold,
    output logic                o_rom_req,
    input  logic                i_rom_valid,
    input  logic [OPCODE_W-1:0] i_rom_data,
    input  logic                i_mc_cont,
    input  logic                i_s2_req,
    input  logic                i_s3_req,
    input  logic                i_s5_req,
    output logic                o_mem_start,
    input  logic                i_mem_done,
    output logic [OPCODE_W-1:0] o_instr_buffer,
    output logic [STAGE_W-1:0]  o_ci_stage,
    output logic                o_s1_done_tick,
    output logic                o_s2_done_tick,
    output logic                o_s3_done_tick,
    output logic                o_s5_done_tick,
    output logic                o_exec_tick,
    output logic                o_instr_done,
    output logic                o_stage_ovf,
    output logic                o_bus_err
);

    if (TIMEOUT_CYCLES == 0 || TIMEOUT_CYCLES > 255) begin : g_timeout_out_of_range
    end

    seq_state_e state;
    logic       mem_wait;
    logic       rom_ack_c;
    logic       mem_ack_c;
    logic       timeout_c;
    logic       phase_done_c;

    assign rom_ack_c    = o_rom_req & i_rom_valid;
    // mem_start is high only on the entry cycle, where a done is not accepted.
    assign mem_ack_c    = i_mem_done & ~o_mem_start;
    assign phase_done_c = ~mem_wait | mem_ack_c | timeout_c;

`ifdef MC8051_MEM_TIMEOUT_EN
    logic wait_c;

    always_comb begin
        wait_c = 1'b0;
        if (!i_hold) begin
            if (state == SEQ_S1) begin
                wait_c = (o_ci_stage == '0) && !rom_ack_c;
            end else if (is_mem_phase(state)) begin
                wait_c = mem_wait && !mem_ack_c;
            end
        end
    end

    seq_wait_timer #(
        .LIMIT (TIMEOUT_CYCLES)
    ) u_wait_timer (
        .i_clk      (i_clk),
        .i_rst_n    (i_rst_n),
        .i_hold     (i_hold),
        .i_wait     (wait_c),
        .o_expire_c (timeout_c)
    );
`else
    assign timeout_c = 1'b0;
    assign o_bus_err = 1'b0;
`endif

    // Sequencer FSM; tick and start pulses default low every cycle.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state          <= SEQ_IDLE;
            mem_wait       <= 1'b0;
            o_rom_req      <= 1'b0;
            o_mem_start    <= 1'b0;
            o_instr_buffer <= OPCODE_NOP;
            o_ci_stage     <= '0;
            o_s1_done_tick <= 1'b0;
            o_s2_done_tick <= 1'b0;
            o_s3_done_tick <= 1'b0;
            o_s5_done_tick <= 1'b0;
            o_exec_tick    <= 1'b0;
            o_instr_done   <= 1'b0;
            o_stage_ovf    <= 1'b0;
`ifdef MC8051_MEM_TIMEOUT_EN
            o_bus_err      <= 1'b0;
`endif
        end else begin
            o_mem_start    <= 1'b0;
            o_s1_done_tick <= 1'b0;
            o_s2_done_tick <= 1'b0;
            o_s3_done_tick <= 1'b0;
            o_s5_done_tick <= 1'b0;
            o_exec_tick    <= 1'b0;
            o_instr_done   <= 1'b0;

            if (!i_hold) begin
`ifdef MC8051_MEM_TIMEOUT_EN
                if (timeout_c) begin
                    o_bus_err <= 1'b1;
                end
`endif
                case (state)
                    SEQ_IDLE: begin
                        o_rom_req <= 1'b1;
                        state     <= SEQ_S1;
                    end
                    SEQ_S1: begin
                        if ((o_ci_stage != '0) || rom_ack_c || timeout_c) begin
                            // A forced completion latches a NOP instead of bus data.
                            if (o_ci_stage == '0) begin
                                o_instr_buffer <= rom_ack_c ? i_rom_data : OPCODE_NOP;
                                o_rom_req      <= 1'b0;
                            end
                            o_s1_done_tick <= 1'b1;
                            o_mem_start    <= i_s2_req;
                            mem_wait       <= i_s2_req;
                            state          <= SEQ_S2;
                        end
                    end
                    SEQ_S2: begin
                        if (phase_done_c) begin
                            o_s2_done_tick <= 1'b1;
                            o_mem_start    <= i_s3_req;
                            mem_wait       <= i_s3_req;
                            state          <= SEQ_S3;
                        end
                    end
                    SEQ_S3: begin
                        if (phase_done_c) begin
                            o_s3_done_tick <= 1'b1;
                            mem_wait       <= 1'b0;
                            state          <= SEQ_S4;
                        end
                    end
                    SEQ_S4: begin
                        o_exec_tick <= 1'b1;
                        o_mem_start <= i_s5_req;
                        mem_wait    <= i_s5_req;
                        state       <= SEQ_S5;
                    end
                    SEQ_S5: begin
                        if (phase_done_c) begin
                            o_s5_done_tick <= 1'b1;
                            mem_wait       <= 1'b0;
                            state          <= SEQ_S6;
                        end
                    end
                    SEQ_S6: begin
                        if (i_mc_cont && (o_ci_stage != CI_STAGE_MAX)) begin
                            o_ci_stage <= o_ci_stage + STAGE_W'(1);
                        end else begin
                            // Continuation past the last stage is flagged and the instruction ends.
                            if (i_mc_cont) begin
                                o_stage_ovf <= 1'b1;
                            end
                            o_ci_stage   <= '0;
                            o_instr_done <= 1'b1;
                            o_rom_req    <= 1'b1;
                        end
                        state <= SEQ_S1;
                    end
                    default: begin
                        state <= SEQ_IDLE;
                    end
                endcase
            end
        end
    end

endmodule
